// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential add/sub ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ADC = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// WIDTH-bit ripple adder computing a + (b ^ {WIDTH{sub}}) + cin with carry-out and signed overflow.
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             v_o
);

  logic [WIDTH-1:0] bx;
  logic             c;

  assign bx = b_i ^ {WIDTH{sub_i}};

  always_comb begin
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ bx[i] ^ c;
      c        = (a_i[i] & bx[i]) | (c & (a_i[i] ^ bx[i]));
    end
    cout_o = c;
  end

  // Overflow: addend signs agree (after inversion) but the sum sign differs.
  assign v_o = (a_i[WIDTH-1] == bx[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu_addsub_seq.sv
// Registered ADD/SUB/ADC/SBC/CMP plus WIDTH-cycle shift-and-add MUL with a tristate bus copy.
// Optional macro ALU_SATURATE_EN clamps ADD/ADC and SUB/SBC results instead of wrapping.
module alu_addsub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             out_en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   core_a, core_b, core_sum;
  logic               core_sub, core_cin, core_cout, core_v;
  logic [WIDTH:0]     hi_next;
  logic [2*WIDTH:0]   shift_tmp;
  logic [WIDTH-1:0]   op_res;

`ifdef ALU_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_res(input logic [2:0] op_f,
                                               input logic [WIDTH-1:0] sum_f,
                                               input logic cout_f);
    if ((op_f == OP_ADD || op_f == OP_ADC) && cout_f) return '1;
    if ((op_f == OP_SUB || op_f == OP_SBC) && !cout_f) return '0;
    return sum_f;
  endfunction
`endif

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (core_a),
    .b_i    (core_b),
    .sub_i  (core_sub),
    .cin_i  (core_cin),
    .sum_o  (core_sum),
    .cout_o (core_cout),
    .v_o    (core_v)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    core_a      = A;
    core_b      = B;
    core_sub    = 1'b0;
    core_cin    = 1'b0;
    hi_next     = '0;
    shift_tmp   = '0;
    op_res      = '0;

    case (state_q)
      ST_MUL: begin
        // The shared core accumulates the multiplicand into the upper half.
        core_a    = acc_q[2*WIDTH-1:WIDTH];
        core_b    = mcand_q;
        hi_next   = acc_q[0] ? {core_cout, core_sum} : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        shift_tmp = {hi_next, acc_q[WIDTH-1:0]};
        acc_d     = shift_tmp[2*WIDTH:1];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d        = acc_d[WIDTH-1:0];
          result_hi_d     = acc_d[2*WIDTH-1:WIDTH];
          flags_d         = '0;
          flags_d[FLAG_C] = |acc_d[2*WIDTH-1:WIDTH];
          flags_d[FLAG_Z] = (acc_d == '0);
          done_d          = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        core_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
        case (op)
          OP_SUB, OP_CMP: core_cin = 1'b1;
          OP_ADC, OP_SBC: core_cin = flags_q[FLAG_C];
          default:        core_cin = 1'b0;
        endcase
`ifdef ALU_SATURATE_EN
        op_res = sat_res(op, core_sum, core_cout);
`else
        op_res = core_sum;
`endif
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d = A;
            acc_d   = {{WIDTH{1'b0}}, B};
            cnt_d   = '0;
            state_d = ST_MUL;
          end else begin
            done_d = 1'b1;
            // Reserved opcodes complete without touching result or flags.
            if (op <= OP_CMP) begin
              flags_d[FLAG_C] = core_cout;
              flags_d[FLAG_Z] = (op_res == '0);
              flags_d[FLAG_N] = op_res[WIDTH-1];
              flags_d[FLAG_V] = core_v;
              if (op != OP_CMP) begin
                result_d    = op_res;
                result_hi_d = '0;
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
    acc_q   <= acc_d;
    cnt_q   <= cnt_d;
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign busy      = (state_q == ST_MUL);
  assign done      = done_q;
  assign out       = out_en ? result_q : {WIDTH{1'bz}};

endmodule

// File: doc/alu_addsub_seq.md
Name: alu_addsub_seq

Overview:
Parametrised, registered successor to the 8-bit combinational adder/subtractor.
- Performs ADD/SUB/ADC/SBC/CMP in one cycle and an unsigned shift-and-add MUL in WIDTH cycles.
- Holds results and a flags register (C, Z, N, V).
- Drives the shared data bus through a tristate stage gated by out_en.
- Sits between the A/B registers and the datapath bus under control-unit sequencing.

Parameters:
- WIDTH, 8: operand and result width in bits (≥ 2).
- CNT_W, $clog2(WIDTH)+1: MUL iteration counter width (derived; do not override).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: launch operation; accepted only when busy=0.
- op, input, 3: opcode: 000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 CMP, 101 MUL; 110/111 reserved.
- A, input, WIDTH: operand A, sampled on accept.
- B, input, WIDTH: operand B, sampled on accept.
- out_en, input, 1: 1 drives result onto out; 0 gives high-Z.
- out, output (tristate), WIDTH: bus copy of result register.
- result, output, WIDTH: result register (low half for MUL).
- result_hi, output, WIDTH: MUL high half; 0 after any non-MUL op.
- flags, output, 4: {C, Z, N, V}, registered.
- busy, output, 1: high while MUL iterates.
- done, output, 1: one-cycle pulse when result/flags are valid.

Behaviour:
- Reset values (state after any clock edge with rst=1): result=0, result_hi=0, flags=0, busy=0, done=0, state=IDLE.
- rst overrides start and aborts a MUL in progress. Nothing is written back.
- States:
  - IDLE: start=1 with op in 0–4 writes result/flags at that edge and sets done=1 for the next cycle; stays in IDLE. start=1 with op=MUL latches A, B, clears the accumulator and counter, sets busy=1, goes to MUL.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper accumulator half; shift right one bit. After exactly WIDTH iterations, write result/result_hi/flags, set busy=0 and done=1 (next cycle), return to IDLE. Latency is start edge + WIDTH edges.
  - start is ignored while busy=1. A and B changes during MUL have no effect.
- Arithmetic uses a single WIDTH-bit ripple core computing A + (B ^ {WIDTH{sub}}) + cin:
  - ADD: sub=0, cin=0.
  - SUB: sub=1, cin=1.
  - ADC: sub=0, cin=C.
  - SBC: sub=1, cin=C.
  - C = core carry-out; for subtraction, C=1 means no borrow.
  - V = signed overflow (operand signs equal after inversion and result sign differs).
  - N = result MSB; Z = (result==0).
- CMP updates flags exactly as SUB; result and result_hi are unchanged.
- MUL flags: Z = (full 2·WIDTH product == 0); N = 0; V = 0; C = |result_hi.
- Reserved opcodes: accepted, done pulses, result/flags unchanged.
- Back-to-back single-cycle ops: start may be high on consecutive cycles; each is accepted and done stays high.
- Tristate: out = result when out_en=1, else all-Z. Combinational from out_en and the result register, so there is no added latency.

Optional Feature:
Macro ALU_SATURATE_EN.
- Defined: ADD/ADC clamp to all-ones on C=1, and SUB/SBC clamp to 0 on C=0 (borrow). Flags are computed from the unclamped sum, except Z and N, which reflect the clamped result. MUL is unaffected.
- Undefined: wrap-around results as described above. No saturation logic is synthesised.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD…OP_MUL);
  - flag bit indices (FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0);
  - the FSM state encoding (IDLE, MUL).
- One sub-module, addsub_core: parametrised WIDTH ripple adder with a sub/invert input, cin, sum, cout and v outputs. It is instantiated once and shared by single-cycle ops and MUL accumulation (sub=0, cin=0).
- The tristate driver is inline.

Test Plan (WIDTH=8):
- Signed overflow: ADD A=0x7F B=0x01 → result 0x80, flags C0 Z0 N1 V1, done on next cycle.
- Borrow then chain: SUB A=0x05 B=0x07 → 0xFE, C=0 N=1. Then SBC A=0x00 B=0x00 → 0xFF, C=0.
- Carry chain and CMP: ADD 0xFF+0x01 → 0x00, C1 Z1. Then ADC 0x00+0x00 → 0x01. Then CMP 0x10,0x10 → Z=1 with result still 0x01.
- MUL: 0xFF×0xFF → busy for 8 cycles, result_hi=0xFE, result=0x01, C=1, done exactly 8 edges after accept. MUL 0x0F×0x11 → 0x00FF, C=0. A start pulse during busy is ignored.
- Reset mid-MUL: assert rst at iteration 4 → next cycle busy=0, result=0, flags=0, state IDLE, no done pulse.
- Tristate: out_en=0 → out all-Z; out_en=1 → out equals result the same cycle. With ALU_SATURATE_EN: ADD 0xF0+0x20 → 0xFF, C=1; SUB 0x05−0x07 → 0x00, Z=1.
